// File: rtl/tt_um_refil_02_pkg.sv
// tt_um_refil_02_pkg: shared control addresses, mode bits and command field positions
package tt_um_refil_02_pkg;
  localparam logic [2:0] A_PRESCALE = 3'd0;
  localparam logic [2:0] A_ENMASK = 3'd1;
  localparam logic [2:0] A_MODE = 3'd2;
  localparam int M_CENTER = 0;
  localparam int M_INVERT = 1;
  localparam int F_STB = 7;
  localparam int F_ADDR_HI = 6;
  localparam int F_ADDR_LO = 4;
  localparam int F_SPACE = 3;
  typedef enum logic {SP_DUTY = 1'b0, SP_CTRL = 1'b1} space_e;
endpackage

// File: rtl/tt_um_refil_02_pwm_channel.sv
// pwm_channel: shadow/active duty pair, compare against shared counter, registered output
module pwm_channel #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [CW-1:0] data,
  input  logic          bnd,
  input  logic [CW-1:0] cnt,
  input  logic          en,
  input  logic          inv,
  output logic          out
);
  logic [CW-1:0] sh, act;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      act <= '0;
      out <= 1'b0;
    end else begin
      if (wr) sh <= data;
      if (bnd) act <= sh;
      out <= en & ((cnt < act) ^ inv);
    end
endmodule

// File: rtl/tt_um_refil_02.sv
// tt_um_refil_02: multi-channel PWM with synchronised register writes, prescaler and edge/center counter
module tt_um_refil_02
  import tt_um_refil_02_pkg::*;
#(
  parameter int NCH = 8,
  parameter int CW = 8,
  parameter int PW = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  localparam logic [CW-1:0] MAXC = '1;
  logic s1, s2, s3, up, wr, wr_ctrl, wr_duty, tick, mchg, at_end, bnd, unused_bits;
  logic [2:0] vld, addr;
  logic [PW-1:0] pre, pcnt;
  logic [CW-1:0] cnt;
  logic [NCH-1:0] en, out_v;
  logic [1:0] mode;
  assign unused_bits = &{1'b0, ui_in[2:0], uio_in};
  // vld keeps writes off until the synchroniser holds real samples, so a strobe held through reset is ignored
  assign wr = s2 & ~s3 & vld[2];
  assign addr = ui_in[F_ADDR_HI:F_ADDR_LO];
  assign wr_ctrl = wr && space_e'(ui_in[F_SPACE]) == SP_CTRL;
  assign wr_duty = wr && space_e'(ui_in[F_SPACE]) == SP_DUTY;
  assign mchg = wr_ctrl && addr == A_MODE && uio_in[M_CENTER] != mode[M_CENTER];
  assign tick = ena && pcnt >= pre;
  assign at_end = mode[M_CENTER] ? (~up && cnt == CW'(1)) : (cnt == MAXC);
  assign bnd = tick & at_end & ~mchg;
  assign uo_out = ena ? 8'(out_v) : 8'h00;
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {s1, s2, s3} <= '0;
      vld <= '0;
      pcnt <= '0;
      pre <= '0;
      en <= '0;
      mode <= '0;
      cnt <= '0;
      up <= 1'b1;
    end else begin
      s1 <= ui_in[F_STB];
      s2 <= s1;
      s3 <= s2;
      vld <= {vld[1:0], 1'b1};
      if (ena) pcnt <= tick ? '0 : pcnt + PW'(1);
      if (wr_ctrl && addr == A_PRESCALE) pre <= uio_in[PW-1:0];
      if (wr_ctrl && addr == A_ENMASK) en <= uio_in[NCH-1:0];
      if (wr_ctrl && addr == A_MODE) mode <= uio_in[1:0];
      if (mchg) begin
        cnt <= '0;
        up <= 1'b1;
      end else if (tick) begin
        if (!mode[M_CENTER]) cnt <= cnt + CW'(1);
        else if (up) begin
          cnt <= cnt == MAXC ? cnt - CW'(1) : cnt + CW'(1);
          up <= cnt != MAXC;
        end else begin
          cnt <= cnt - CW'(1);
          up <= cnt == CW'(1);
        end
      end
    end
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_channel #(.CW(CW)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .wr(wr_duty && addr == 3'(g)),
      .data(uio_in[CW-1:0]),
      .bnd(bnd),
      .cnt(cnt),
      .en(en[g]),
      .inv(mode[M_INVERT]),
      .out(out_v[g])
    );
  end
endmodule

// File: tb/tb_tt_um_refil_02.sv
// tb_tt_um_refil_02: random + directed stimulus on two configurations, period-position reference model, queued scoreboard
module tb_tt_um_refil_02;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo0, uo1, uio_out0, uio_oe0, uio_out1, uio_oe1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;

  tt_um_refil_02 d0 (
    .ui_in(ui_in), .uo_out(uo0), .uio_in(uio_in), .uio_out(uio_out0),
    .uio_oe(uio_oe0), .ena(ena), .clk(clk), .rst_n(rst_n)
  );
  tt_um_refil_02 #(.NCH(3), .CW(4), .PW(2)) d1 (
    .ui_in(ui_in), .uo_out(uo1), .uio_in(uio_in), .uio_out(uio_out1),
    .uio_oe(uio_oe1), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  // reference model: the counter is derived from the tick position inside the current period
  int nch[2] = '{8, 3};
  int cw[2] = '{8, 4};
  int pw[2] = '{8, 2};
  int e[2], pos[2], pre[2], en[2], mode[2];
  int sh[2][8], act[2][8];
  int h1, h2, h3, since;
  logic [7:0] qe0[$], qe1[$];

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      e[k] = 0; pos[k] = 0; pre[k] = 0; en[k] = 0; mode[k] = 0;
      for (int i = 0; i < 8; i++) begin sh[k][i] = 0; act[k][i] = 0; end
    end
    h1 = 0; h2 = 0; h3 = 0; since = 0;
  endtask

  task automatic push(int k, logic [7:0] v);
    if (k == 0) qe0.push_back(v);
    else qe1.push_back(v);
  endtask

  always @(negedge rst_n) begin
    mreset();
    qe0.delete(); qe1.delete();
    qe0.push_back(8'h00); qe1.push_back(8'h00);
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mreset();
      push(0, 8'h00); push(1, 8'h00);
    end else begin
      bit w, tick, mchg;
      int mx, per, c, a;
      logic [7:0] o;
      w = since >= 3 && h2 == 1 && h3 == 0;
      a = int'(ui_in[6:4]);
      for (int k = 0; k < 2; k++) begin
        mx = (1 << cw[k]) - 1;
        per = (mode[k] & 1) ? 2 * mx : mx + 1;
        c = (mode[k] & 1) ? (pos[k] <= mx ? pos[k] : 2 * mx - pos[k]) : pos[k];
        o = 8'h00;
        for (int i = 0; i < nch[k]; i++)
          if ((en[k] >> i) & 1) o[i] = (c < act[k][i]) ^ ((mode[k] >> 1) & 1);
        push(k, ena ? o : 8'h00);
        tick = ena && e[k] >= pre[k];
        if (ena) e[k] = tick ? 0 : e[k] + 1;
        mchg = w && ui_in[3] && a == 2 && int'(uio_in[0]) != (mode[k] & 1);
        if (mchg) pos[k] = 0;
        else if (tick) begin
          if (pos[k] == per - 1) begin
            pos[k] = 0;
            for (int i = 0; i < 8; i++) act[k][i] = sh[k][i];
          end else pos[k]++;
        end
        if (w && !ui_in[3] && a < nch[k]) sh[k][a] = int'(uio_in) & mx;
        if (w && ui_in[3] && a == 0) pre[k] = int'(uio_in) & ((1 << pw[k]) - 1);
        if (w && ui_in[3] && a == 1) en[k] = int'(uio_in) & ((1 << nch[k]) - 1);
        if (w && ui_in[3] && a == 2) mode[k] = int'(uio_in) & 3;
      end
      if (since < 3) since++;
      h3 = h2; h2 = h1; h1 = int'(ui_in[7]);
    end
  end

  task automatic check(string name, logic [7:0] act_v, logic [7:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      if (fails <= 20) $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (qe0.size() == 0 || qe1.size() == 0) begin
      tests++;
      fails++;
      if (fails <= 20) $display("FAIL scoreboard underflow at %0t: got %0d entries expected 1", $time, qe0.size());
    end else begin
      check("uo_out_nch8", uo0, qe0.pop_front());
      check("uo_out_nch3", uo1, qe1.pop_front());
      check("uio_const", uio_out0 | uio_oe0 | uio_out1 | uio_oe1, 8'h00);
    end
  end

  task automatic step(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wr(bit space, int addr, int data);
    ui_in = {1'b1, 3'(addr), space, 3'($urandom)};
    uio_in = 8'(data);
    step(4);
    ui_in[7] = 1'b0;
    step(4);
    uio_in = 8'($urandom);
  endtask

  task automatic mid_reset(int n);
    @(posedge clk); #2;
    rst_n = 1'b0;
    step(n);
    rst_n = 1'b1;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);
    wr(0, 0, 64); wr(1, 1, 8'h01); wr(1, 0, 0);
    step(600);
    wr(1, 2, 1); wr(0, 1, 128); wr(1, 1, 8'h03); wr(1, 0, 1);
    step(2200);
    wr(1, 2, 0); wr(0, 0, 100);
    step(300);
    wr(0, 0, 200);
    step(1000);
    wr(1, 2, 2); wr(0, 2, 0); wr(1, 1, 8'h04);
    step(600);
    wr(1, 1, 8'h00);
    step(100);
    wr(1, 2, 0); wr(1, 1, 8'h07);
    step(130);
    ena = 1'b0; step(50); ena = 1'b1;
    step(400);
    ena = 1'b0; wr(0, 1, 30); step(20); ena = 1'b1;
    step(600);
    wr(0, 5, 77);
    step(300);
    mid_reset(3);
    step(20);
    @(posedge clk); #2;
    rst_n = 1'b0;
    step(1);
    ui_in = 8'h80; uio_in = 8'hff;
    step(3);
    rst_n = 1'b1;
    step(10);
    ui_in = 8'h00;
    step(5);
    wr(1, 1, 8'h01);
    step(600);
    for (int it = 0; it < 150; it++) begin
      int op;
      op = $urandom_range(0, 29);
      if (op < 18) begin
        bit sp;
        int ad;
        sp = 1'($urandom);
        ad = $urandom_range(0, 7);
        wr(sp, ad, (sp && ad == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255));
      end else if (op < 24) begin
        ena = 1'b0; step($urandom_range(1, 60)); ena = 1'b1;
      end else if (op == 24) mid_reset($urandom_range(1, 4));
      step($urandom_range(0, 200));
    end
    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
